// File: rtl/perf_monitor.sv
// Multi-channel PC-window performance monitor: per-channel start/stop triggered
// saturating counters with a registered readout port.
module perf_monitor #(
    parameter int unsigned PC_WIDTH        = 12,
    parameter int unsigned COUNT_WIDTH     = 32,
    parameter int unsigned CHANNELS        = 4,
    parameter logic [PC_WIDTH-1:0] DEFAULT_STOP_PC = {PC_WIDTH{1'b1}},
    localparam int unsigned CHAN_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   cpu_clk,
    input  logic                   resetN,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic                   cfg_we,
    input  logic [CHAN_W-1:0]      cfg_chan,
    input  logic                   cfg_enable,
    input  logic [1:0]             cfg_mode,
    input  logic [PC_WIDTH-1:0]    cfg_start_pc,
    input  logic [PC_WIDTH-1:0]    cfg_stop_pc,
    input  logic                   clear_all,
    input  logic [CHAN_W-1:0]      rd_chan,
    output logic [COUNT_WIDTH-1:0] rd_count,
    output logic [CHANNELS-1:0]    running,
    output logic [CHANNELS-1:0]    done,
    output logic [CHANNELS-1:0]    overflow
);

    typedef enum logic [1:0] {StIdle, StArmed, StRunning, StDone} state_e;

    logic [PC_WIDTH-1:0]    pc_prev;
    logic [COUNT_WIDTH-1:0] count_vec [CHANNELS];

    always_ff @(posedge cpu_clk) begin
        if (!resetN) begin
            pc_prev <= '0;
        end else begin
            pc_prev <= pc;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        state_e                 state_q, state_d;
        logic                   enable_q, enable_d;
        logic [1:0]             mode_q, mode_d;
        logic [PC_WIDTH-1:0]    start_q, start_d;
        logic [PC_WIDTH-1:0]    stop_q, stop_d;
        logic [COUNT_WIDTH-1:0] count_q, count_d;
        logic                   ovf_q, ovf_d;
        logic                   cfg_hit;
        logic                   qualify;
        logic                   inc;

        assign cfg_hit = cfg_we && (cfg_chan == CHAN_W'(g));

        always_comb begin
            state_d  = state_q;
            enable_d = enable_q;
            mode_d   = mode_q;
            start_d  = start_q;
            stop_d   = stop_q;
            count_d  = count_q;
            ovf_d    = ovf_q;
            qualify  = 1'b0;
            inc      = 1'b1;

            // Start is only looked for while armed, stop only while running,
            // so start == stop still opens the window.
            unique case (state_q)
                StArmed: begin
                    if (pc == start_q) begin
                        state_d = StRunning;
                        qualify = 1'b1;
                    end
                end
                StRunning: begin
                    if (pc == stop_q) begin
                        state_d = StDone;
                    end else begin
                        qualify = 1'b1;
                    end
                end
                default: ;
            endcase

            unique case (mode_q)
                2'd1:    inc = (pc != pc_prev);
                2'd2:    inc = (pc == start_q) && (pc_prev != start_q);
                default: inc = 1'b1;
            endcase

            if (qualify && inc) begin
                if (&count_q) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + COUNT_WIDTH'(1);
                end
            end

            if (cfg_hit) begin
                enable_d = cfg_enable;
                mode_d   = cfg_mode;
                start_d  = cfg_start_pc;
                stop_d   = cfg_stop_pc;
            end

            // A restart overrides any match evaluated above in the same cycle.
            if (cfg_hit || clear_all) begin
                count_d = '0;
                ovf_d   = 1'b0;
                state_d = enable_d ? StArmed : StIdle;
            end
        end

        always_ff @(posedge cpu_clk) begin
            if (!resetN) begin
                state_q  <= StIdle;
                enable_q <= 1'b0;
                mode_q   <= 2'd0;
                start_q  <= '0;
                stop_q   <= DEFAULT_STOP_PC;
                count_q  <= '0;
                ovf_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                enable_q <= enable_d;
                mode_q   <= mode_d;
                start_q  <= start_d;
                stop_q   <= stop_d;
                count_q  <= count_d;
                ovf_q    <= ovf_d;
            end
        end

        assign running[g]   = (state_q == StRunning);
        assign done[g]      = (state_q == StDone);
        assign overflow[g]  = ovf_q;
        assign count_vec[g] = count_q;
    end

    always_ff @(posedge cpu_clk) begin
        if (!resetN) begin
            rd_count <= '0;
        end else if (32'(rd_chan) < CHANNELS) begin
            rd_count <= count_vec[rd_chan];
        end else begin
            rd_count <= '0;
        end
    end

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: expectations are queued when stimulus is
// driven and popped when the corresponding output is sampled.
module tb_perf_monitor;

    logic        cpu_clk = 1'b0;
    logic        resetN;
    logic [11:0] pc;
    logic        cfg_we;
    logic [1:0]  cfg_chan;
    logic        cfg_enable;
    logic [1:0]  cfg_mode;
    logic [11:0] cfg_start_pc;
    logic [11:0] cfg_stop_pc;
    logic        clear_all;
    logic [1:0]  rd_chan;
    logic [31:0] rd_count;
    logic [3:0]  running, done, overflow;
    logic [3:0]  s_rd_count;
    logic [3:0]  s_running, s_done, s_overflow;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 cpu_clk = ~cpu_clk;

    perf_monitor #(.PC_WIDTH(12), .COUNT_WIDTH(32), .CHANNELS(4)) dut (
        .cpu_clk(cpu_clk), .resetN(resetN), .pc(pc), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
        .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_start_pc(cfg_start_pc),
        .cfg_stop_pc(cfg_stop_pc), .clear_all(clear_all), .rd_chan(rd_chan),
        .rd_count(rd_count), .running(running), .done(done), .overflow(overflow)
    );

    // Narrow counters to exercise saturation; shares all stimulus with dut.
    perf_monitor #(.PC_WIDTH(12), .COUNT_WIDTH(4), .CHANNELS(4)) dut_small (
        .cpu_clk(cpu_clk), .resetN(resetN), .pc(pc), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
        .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_start_pc(cfg_start_pc),
        .cfg_stop_pc(cfg_stop_pc), .clear_all(clear_all), .rd_chan(rd_chan),
        .rd_count(s_rd_count), .running(s_running), .done(s_done), .overflow(s_overflow)
    );

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag   = tag;
        e.value = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_underflow: observed %0h expected none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.value) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input logic en, input logic [1:0] mode,
                       input logic [11:0] start, input logic [11:0] stop);
        cfg_we       = 1'b1;
        cfg_chan     = ch;
        cfg_enable   = en;
        cfg_mode     = mode;
        cfg_start_pc = start;
        cfg_stop_pc  = stop;
        step();
        cfg_we       = 1'b0;
    endtask

    task automatic drive_pc(input logic [11:0] p);
        pc = p;
        step();
    endtask

    task automatic read_chan(input logic [1:0] ch);
        rd_chan = ch;
        step();
    endtask

    initial begin
        resetN = 1'b0; pc = '0; cfg_we = 1'b0; cfg_chan = '0; cfg_enable = 1'b0;
        cfg_mode = '0; cfg_start_pc = '0; cfg_stop_pc = '0; clear_all = 1'b0; rd_chan = '0;
        step();
        step();
        resetN = 1'b1;

        // Reset state
        expect_val("rst_running", 32'h0);
        expect_val("rst_done", 32'h0);
        expect_val("rst_overflow", 32'h0);
        expect_val("rst_rd_count", 32'h0);
        check(32'(running));
        check(32'(done));
        check(32'(overflow));
        read_chan(2'd0);
        check(rd_count);

        // ch0 cycle mode, window 0x010..0x020
        cfg(2'd0, 1'b1, 2'd0, 12'h010, 12'h020);
        expect_val("m0_running_start", 32'h1);
        drive_pc(12'h010);
        check(32'(running[0]));
        for (int p = 'h11; p <= 'h1F; p++) drive_pc(12'(p));
        expect_val("m0_done", 32'h1);
        expect_val("m0_running_after", 32'h0);
        expect_val("m0_count", 32'd16);
        drive_pc(12'h020);
        check(32'(done[0]));
        check(32'(running[0]));
        read_chan(2'd0);
        check(rd_count);

        // ch1 PC-change mode; pc_prev already holds 0x010 at the start cycle
        pc = 12'h010;
        cfg(2'd1, 1'b1, 2'd1, 12'h010, 12'h020);
        drive_pc(12'h010);
        drive_pc(12'h010);
        drive_pc(12'h011);
        drive_pc(12'h011);
        drive_pc(12'h012);
        expect_val("m1_done", 32'h1);
        expect_val("m1_count", 32'd2);
        drive_pc(12'h020);
        check(32'(done[1]));
        read_chan(2'd1);
        check(rd_count);

        // ch2 start-entry mode
        pc = 12'h000;
        cfg(2'd2, 1'b1, 2'd2, 12'h005, 12'hFFF);
        for (int i = 0; i < 3; i++) begin
            drive_pc(12'h005);
            drive_pc(12'h006);
            drive_pc(12'h007);
        end
        expect_val("m2_done", 32'h1);
        expect_val("m2_count", 32'd3);
        drive_pc(12'hFFF);
        check(32'(done[2]));
        read_chan(2'd2);
        check(rd_count);

        // ch3 saturation on the 4-bit instance, 21 qualifying cycles
        pc = 12'h000;
        cfg(2'd3, 1'b1, 2'd0, 12'h200, 12'h300);
        drive_pc(12'h200);
        for (int i = 0; i < 20; i++) drive_pc(12'h201);
        expect_val("sat_overflow", 32'h1);
        expect_val("sat_running", 32'h1);
        expect_val("sat_count", 32'd15);
        expect_val("wide_count", 32'd21);
        expect_val("wide_no_overflow", 32'h0);
        check(32'(s_overflow[3]));
        check(32'(s_running[3]));
        read_chan(2'd3);
        check(32'(s_rd_count));
        check(rd_count);
        check(32'(overflow[3]));

        // cfg write clears count/overflow and re-arms
        cfg(2'd3, 1'b1, 2'd0, 12'h200, 12'h300);
        expect_val("recfg_overflow", 32'h0);
        expect_val("recfg_running", 32'h0);
        expect_val("recfg_done", 32'h0);
        expect_val("recfg_count", 32'h0);
        expect_val("recfg_armed", 32'h1);
        check(32'(s_overflow[3]));
        check(32'(s_running[3]));
        check(32'(s_done[3]));
        read_chan(2'd3);
        check(32'(s_rd_count));
        drive_pc(12'h200);
        check(32'(s_running[3]));

        // Mid-run clear_all together with disabling cfg write to ch3
        drive_pc(12'h201);
        drive_pc(12'h201);
        clear_all = 1'b1;
        cfg(2'd3, 1'b0, 2'd0, 12'h200, 12'h300);
        clear_all = 1'b0;
        expect_val("clr_running", 32'h0);
        expect_val("clr_done", 32'h0);
        expect_val("clr_overflow", 32'h0);
        check(32'(running));
        check(32'(done));
        check(32'(overflow));
        for (int c = 0; c < 4; c++) begin
            expect_val($sformatf("clr_count%0d", c), 32'h0);
            read_chan(2'(c));
            check(rd_count);
        end
        expect_val("clr_rearmed", 32'h3);
        drive_pc(12'h010);
        check(32'(running));

        // Same again with reset asserted in that cycle
        drive_pc(12'h011);
        resetN    = 1'b0;
        clear_all = 1'b1;
        cfg(2'd3, 1'b1, 2'd0, 12'h011, 12'h300);
        clear_all = 1'b0;
        resetN    = 1'b1;
        expect_val("rstmix_running", 32'h0);
        expect_val("rstmix_done", 32'h0);
        expect_val("rstmix_rd_count", 32'h0);
        expect_val("rstmix_idle", 32'h0);
        expect_val("rstmix_count0", 32'h0);
        check(32'(running));
        check(32'(done));
        check(rd_count);
        drive_pc(12'h011);
        drive_pc(12'h000);
        check(32'(running | done));
        read_chan(2'd0);
        check(rd_count);

        // start_pc == stop_pc
        pc = 12'h000;
        cfg(2'd0, 1'b1, 2'd0, 12'h100, 12'h100);
        expect_val("eq_running", 32'h1);
        drive_pc(12'h100);
        check(32'(running[0]));
        drive_pc(12'h101);
        expect_val("eq_done", 32'h1);
        expect_val("eq_count", 32'd2);
        drive_pc(12'h100);
        check(32'(done[0]));
        read_chan(2'd0);
        check(rd_count);

        // Reserved mode counts cycles
        pc = 12'h000;
        cfg(2'd1, 1'b1, 2'd3, 12'h300, 12'h310);
        drive_pc(12'h300);
        drive_pc(12'h300);
        drive_pc(12'h305);
        expect_val("m3_count", 32'd3);
        drive_pc(12'h310);
        read_chan(2'd1);
        check(rd_count);

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/perf_monitor.md
# perf_monitor

Multi-channel, parametrised successor to the single performance counter. It watches the CPU instruction address on `cpu_clk` and runs `CHANNELS` independent counters, each with its own runtime-programmed start PC, stop PC and counting mode. Counters saturate instead of wrapping. Results are read through a registered readout port that feeds the hex/perf digit renderers. It sits beside the CPU in the top level, tapping `inst_address`.

## Interface
Parameters:
- `PC_WIDTH`, 12: width of watched program counter.
- `COUNT_WIDTH`, 32: width of each channel counter.
- `CHANNELS`, 4: number of independent channels (≥1).
- `DEFAULT_STOP_PC`, 2**PC_WIDTH-1: stop PC loaded into every channel at reset.

Ports:
- `cpu_clk`  in  1  sole clock. One clock; all state on its rising edge.
- `resetN`  in  1  synchronous, active-low reset.
- `pc`  in  PC_WIDTH  current instruction address.
- `cfg_we`  in  1  write strobe for one channel's configuration.
- `cfg_chan`  in  $clog2(CHANNELS) (min 1)  channel written.
- `cfg_enable`  in  1  enable bit written.
- `cfg_mode`  in  2  mode written: 0 = cycles, 1 = PC changes, 2 = start-PC entries, 3 = reserved (acts as 0).
- `cfg_start_pc`, `cfg_stop_pc`  in  PC_WIDTH each  trigger addresses written.
- `clear_all`  in  1  restart all channels.
- `rd_chan`  in  $clog2(CHANNELS) (min 1)  readout select.
- `rd_count`  out  COUNT_WIDTH  count of channel `rd_chan`, registered.
- `running`, `done`, `overflow`  out  CHANNELS each  per-channel status, registered.

## Operation
- Per-channel state machine:
  - IDLE (disabled).
  - ARMED (waiting for `pc == start_pc`).
  - RUNNING (counting).
  - DONE (holds count).
- Transitions:
  - IDLE stays IDLE.
  - ARMED → RUNNING on start match.
  - RUNNING → DONE on stop match.
  - DONE stays DONE until a cfg write or `clear_all`.
- Start beats stop: in ARMED with `pc == start_pc == stop_pc`, go to RUNNING. Stop is checked only in RUNNING.
- A qualifying cycle is either the start-match cycle (ARMED → RUNNING), or any RUNNING cycle that is not a stop match. The stop-match cycle is never counted.
- Increment rule, per qualifying cycle:
  - Mode 0: +1.
  - Mode 1: +1 if `pc != pc_prev`.
  - Mode 2: +1 if `pc == start_pc && pc_prev != start_pc`.
- `pc_prev` is a single shared register. It loads `pc` every cycle and resets to 0.
- Saturation: at all-ones the count holds and `overflow[ch]` sets. `overflow` stays set until a cfg write to that channel, `clear_all`, or reset.
- cfg write to channel c, in any state, including mid-run:
  - Loads enable, mode, start and stop.
  - Sets count to 0 and clears overflow.
  - Next state is ARMED if `cfg_enable`, else IDLE.
- `clear_all`: every channel's count → 0 and overflow → 0; state → ARMED if enabled, else IDLE. Configuration is kept.
- `cfg_we` and `clear_all` in the same cycle: both take effect. The written channel uses the new config. The two actions do not conflict.
- A channel restarted in a given cycle does not evaluate a start match in that cycle.
- `running[ch]` = state is RUNNING. `done[ch]` = state is DONE.
- `rd_chan` values ≥ CHANNELS read as 0.

## Timing
- Reset values:
  - All channels IDLE: enable 0, mode 0, start_pc 0, stop_pc `DEFAULT_STOP_PC`.
  - Counts 0.
  - `rd_count`, `running`, `done`, `overflow` all 0. `pc_prev` 0.
- Reset has priority over `cfg_we` and `clear_all`.
- Count and state update on the edge that samples the triggering `pc`. Status outputs reflect the new state after that edge.
- `rd_count` latency: 1 cycle. It returns the value of the channel count register as of the edge that samples `rd_chan`, i.e. the count before that edge's update.
- Cycle-mode example: start at cycle t, stop sampled at cycle t+k gives a final count of k.
- Throughput: every cycle. There is no backpressure and no handshake.

## Test plan
- Reset, then program ch0 as mode 0, start 0x010, stop 0x020, enabled. Drive pc 0x010..0x01F one per cycle, then 0x020. Required: `done[0]` = 1, `rd_count` = 16, `running[0]` = 0.
- ch1 in mode 1 with the same window. Drive pc 0x010, 0x010, 0x011, 0x011, 0x012, 0x020. Required: count = 2 (the start cycle does not change relative to the initial `pc_prev` value of 0x010 held the prior cycle).
- ch2 in mode 2, start 0x005, stop 0xFFF. Loop pc 0x005, 0x006, 0x007 three times, then 0xFFF. Required: count = 3, `done[2]` = 1.
- `COUNT_WIDTH` = 4, mode 0, held in RUNNING for 20 cycles. Required: count = 15 and `overflow` = 1. Then a cfg write to the same channel. Required: count = 0, `overflow` = 0, state ARMED.
- Mid-run `clear_all` together with `cfg_we` to ch3 (enable 0). Required: every channel count = 0, enabled channels ARMED, ch3 IDLE. Repeat with `resetN` = 0 in the same cycle: everything returns to reset values.
- Set `start_pc` = `stop_pc` = 0x100 and drive pc 0x100, 0x101, 0x100. Required: RUNNING after the first 0x100, DONE after the second, count = 2.
